// File: rtl/tdm_demux_pkg.sv
// ============================================================================
// Module : tdm_demux_pkg
// Brief  : Shared types and constants for the TDM demultiplexer.
//          The frame length depends on DEMUX_PARITY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tdm_demux_pkg;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int SLOT_W = 3;

`ifdef DEMUX_PARITY_EN
  localparam int NSLOT = 5;
`else
  localparam int NSLOT = 4;
`endif

  // Words held in staging before the final beat of a frame arrives.
  localparam int NSTAGE = NSLOT - 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);

endpackage

`default_nettype wire

// File: rtl/demux_sequencer.sv
// ============================================================================
// Module : demux_sequencer
// Brief  : Slot tracking FSM (HUNT/LOCKED) with slot counter, capture
//          steering, commit strobe and registered sync_err pulse.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_sequencer
  import tdm_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sync,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              cap_en,
  output logic [SLOT_W-1:0] cap_idx,
  output logic              commit,
  output logic              sync_err
);

  state_t            state, state_nxt;
  logic [SLOT_W-1:0] slot_nxt;
  logic              sync_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      slot     <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      slot     <= slot_nxt;
      sync_err <= sync_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    slot_nxt     = slot;
    sync_err_nxt = 1'b0;
    cap_en       = 1'b0;
    cap_idx      = '0;
    commit       = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_sync) begin
            cap_en    = 1'b1;
            slot_nxt  = SLOT_W'(1);
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (slot == '0) begin
            if (in_sync) begin
              cap_en   = 1'b1;
              slot_nxt = SLOT_W'(1);
            end else begin
              sync_err_nxt = 1'b1;
              state_nxt    = HUNT;
              slot_nxt     = '0;
            end
          end else if (in_sync) begin
            // Early marker: abandon the partial frame and restart at slot 0.
            sync_err_nxt = 1'b1;
            cap_en       = 1'b1;
            slot_nxt     = SLOT_W'(1);
          end else if (slot == LAST_SLOT) begin
            commit   = 1'b1;
            slot_nxt = '0;
          end else begin
            cap_en   = 1'b1;
            cap_idx  = slot;
            slot_nxt = slot + SLOT_W'(1);
          end
        end
        default: begin
          state_nxt = HUNT;
          slot_nxt  = '0;
        end
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

`default_nettype wire

// File: rtl/tdm_demultiplexer.sv
// ============================================================================
// Module : tdm_demultiplexer
// Brief  : Four-lane TDM receiver; staging, registered frame outputs and
//          optional parity check (enabled by macro DEMUX_PARITY_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demultiplexer
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sync,
  input  logic [WIDTH-1:0]  in_data,
  output logic [WIDTH-1:0]  out0,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3,
  output logic              out_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              sync_err,
  output logic              parity_err
);

  logic              cap_en;
  logic [SLOT_W-1:0] cap_idx;
  logic              commit;
  logic [WIDTH-1:0]  staging [NSTAGE];

  demux_sequencer u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .slot     (slot),
    .locked   (locked),
    .cap_en   (cap_en),
    .cap_idx  (cap_idx),
    .commit   (commit),
    .sync_err (sync_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTAGE; i++) staging[i] <= '0;
    end else begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (cap_en && (cap_idx == SLOT_W'(i))) staging[i] <= in_data;
      end
    end
  end

`ifdef DEMUX_PARITY_EN
  logic par_ok;
  assign par_ok = ((staging[0] ^ staging[1] ^ staging[2] ^ staging[3]) == in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0       <= '0;
      out1       <= '0;
      out2       <= '0;
      out3       <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      out_valid  <= commit && par_ok;
      parity_err <= commit && !par_ok;
      if (commit && par_ok) begin
        out0 <= staging[0];
        out1 <= staging[1];
        out2 <= staging[2];
        out3 <= staging[3];
      end
    end
  end
`else
  assign parity_err = 1'b0;

  // The final lane is taken straight from the bus on the commit beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0      <= '0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= commit;
      if (commit) begin
        out0 <= staging[0];
        out1 <= staging[1];
        out2 <= staging[2];
        out3 <= in_data;
      end
    end
  end
`endif

endmodule

`default_nettype wire
